warp_scheduler: RTL

- Sequences the per-warp instruction lifecycle (fetch, decode, request, wait, execute, update) for a compute core.
- Selects one ready warp at a time by round-robin and drives the shared warp_state bus seen by the decoder, LSU and ALUs.
- Owns per-warp program counters, branch redirection and halt/done tracking.
- Sits between the instruction fetcher and the core datapath; one instance per core.

---
 rtl/warp_scheduler_pkg.sv | 24 ++
 rtl/warp_scheduler_rr_arbiter.sv | 38 +++
 rtl/warp_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/warp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : warp_scheduler_pkg
// Description : Shared types and constants for the warp scheduler slice.
// Revision    : 1.0 - initial release
// ============================================================================
package warp_scheduler_pkg;

    localparam int c_DEFAULT_NUM_WARPS = 4;
    localparam int c_PC_INCREMENT      = 4;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

endpackage
`default_nettype wire

// File: rtl/warp_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : warp_scheduler_rr_arbiter
// Description : Combinational round-robin pick of the first request at or
//               after the pointer, wrapping modulo NUM_WARPS.
// Revision    : 1.0 - initial release
// ============================================================================
module warp_scheduler_rr_arbiter #(
    parameter int NUM_WARPS     = 4,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0]     i_request,
    input  logic [WARP_ID_WIDTH-1:0] i_pointer,
    output logic [NUM_WARPS-1:0]     o_grant,
    output logic [WARP_ID_WIDTH-1:0] o_grant_idx,
    output logic                     o_any_valid
);

    logic [WARP_ID_WIDTH-1:0] w_cand;

    // Scan farthest-first so the nearest request to the pointer wins last.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_valid = 1'b0;
        w_cand      = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            w_cand = i_pointer + WARP_ID_WIDTH'(i);
            if (i_request[w_cand]) begin
                o_grant_idx = w_cand;
                o_any_valid = 1'b1;
            end
        end
        o_grant[o_grant_idx] = o_any_valid;
    end

endmodule
`default_nettype wire

// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : warp_scheduler
// Description : Round-robin warp selection and per-warp instruction lifecycle
//               sequencing with PC, branch and halt tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS     = c_DEFAULT_NUM_WARPS,
    parameter int PC_WIDTH      = 32,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PC_WIDTH-1:0]      base_pc,
    input  logic [NUM_WARPS-1:0]     warp_mask,
    output logic                     fetch_req,
    output logic [PC_WIDTH-1:0]      fetch_pc,
    input  logic                     fetch_ready,
    output warp_state_t              warp_state,
    output logic [WARP_ID_WIDTH-1:0] current_warp,
    input  logic                     decoded_halt,
    input  logic                     decoded_mem_read_enable,
    input  logic                     decoded_mem_write_enable,
    input  logic                     decoded_branch,
    input  logic                     branch_taken,
    input  logic [PC_WIDTH-1:0]      branch_target,
    input  logic                     lsu_done,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    logic [1:0]               r_sched_state;
    logic [1:0]               w_sched_next;
    warp_state_t              r_warp_state;
    warp_state_t              w_warp_next;
    logic [PC_WIDTH-1:0]      r_pc [NUM_WARPS];
    logic [NUM_WARPS-1:0]     r_halted;
    logic [NUM_WARPS-1:0]     r_current_onehot;
    logic [WARP_ID_WIDTH-1:0] r_current_warp;
    logic [WARP_ID_WIDTH-1:0] r_rr_ptr;
    logic                     r_fetch_req;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_branch_taken;
    logic [PC_WIDTH-1:0]      r_branch_target;
    logic [NUM_WARPS-1:0]     w_grant;
    logic [WARP_ID_WIDTH-1:0] w_grant_idx;
    logic                     w_any_valid;
    logic                     w_mem_op;

    assign w_mem_op     = decoded_mem_read_enable | decoded_mem_write_enable;
    assign fetch_req    = r_fetch_req;
    assign fetch_pc     = r_pc[r_current_warp];
    assign warp_state   = r_warp_state;
    assign current_warp = r_current_warp;
    assign busy         = r_busy;
    assign done         = r_done;

    warp_scheduler_rr_arbiter #(
        .NUM_WARPS     (NUM_WARPS),
        .WARP_ID_WIDTH (WARP_ID_WIDTH)
    ) u_rr_arbiter (
        .i_request   (~r_halted),
        .i_pointer   (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_valid (w_any_valid)
    );

    always_comb begin
        w_sched_next = r_sched_state;
        w_warp_next  = r_warp_state;
        case (r_sched_state)
            S_IDLE: begin
                w_warp_next = WARP_IDLE;
                if (start && (warp_mask != '0)) begin
                    w_sched_next = S_SELECT;
                end
            end
            S_SELECT: begin
                if (w_any_valid) begin
                    w_warp_next  = WARP_FETCH;
                    w_sched_next = S_RUN;
                end else begin
                    w_warp_next  = WARP_DONE;
                    w_sched_next = S_IDLE;
                end
            end
            S_RUN: begin
                case (r_warp_state)
                    WARP_FETCH:   if (fetch_ready) w_warp_next = WARP_DECODE;
                    WARP_DECODE:  w_warp_next = WARP_REQUEST;
                    WARP_REQUEST: w_warp_next = WARP_WAIT;
                    WARP_WAIT:    if (!w_mem_op || lsu_done) w_warp_next = WARP_EXECUTE;
                    WARP_EXECUTE: w_warp_next = WARP_UPDATE;
                    WARP_UPDATE: begin
                        w_warp_next  = WARP_IDLE;
                        w_sched_next = S_SELECT;
                    end
                    default: begin
                        w_warp_next  = WARP_IDLE;
                        w_sched_next = S_IDLE;
                    end
                endcase
            end
            default: begin
                w_warp_next  = WARP_IDLE;
                w_sched_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sched_state    <= S_IDLE;
            r_warp_state     <= WARP_IDLE;
            r_halted         <= '0;
            r_current_onehot <= '0;
            r_current_warp   <= '0;
            r_rr_ptr         <= '0;
            r_fetch_req      <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_branch_taken   <= 1'b0;
            r_branch_target  <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_pc[i] <= '0;
            end
        end else begin
            r_sched_state <= w_sched_next;
            r_warp_state  <= w_warp_next;
            r_done        <= 1'b0;
            case (r_sched_state)
                S_IDLE: begin
                    // An empty mask completes immediately without leaving idle.
                    if (start) begin
                        for (int i = 0; i < NUM_WARPS; i++) begin
                            r_pc[i] <= base_pc;
                        end
                        r_halted <= ~warp_mask;
                        r_busy   <= |warp_mask;
                        r_done   <= ~|warp_mask;
                    end
                end
                S_SELECT: begin
                    if (w_any_valid) begin
                        r_current_warp   <= w_grant_idx;
                        r_current_onehot <= w_grant;
                        r_rr_ptr         <= w_grant_idx + WARP_ID_WIDTH'(1);
                        r_fetch_req      <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    case (r_warp_state)
                        WARP_FETCH: begin
                            if (fetch_ready) r_fetch_req <= 1'b0;
                        end
                        WARP_EXECUTE: begin
                            r_branch_taken  <= branch_taken;
                            r_branch_target <= branch_target;
                        end
                        WARP_UPDATE: begin
                            if (decoded_halt) begin
                                r_halted <= r_halted | r_current_onehot;
                            end else if (decoded_branch && r_branch_taken) begin
                                r_pc[r_current_warp] <= r_branch_target;
                            end else begin
                                r_pc[r_current_warp] <= r_pc[r_current_warp] + PC_WIDTH'(c_PC_INCREMENT);
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
